uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received word with its parity-error tag into a first-word-fall-through FIFO and presents them on a valid/ready stream. It also flags overruns and raises an inter-character idle-timeout pulse, so host logic can frame variable-length packets.

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/fifo_mem_sdp.sv | 30 +++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_rx_fifo_pkg;

  typedef enum logic [1:0] {
    UART_RXF_EMPTY = 2'd0,
    UART_RXF_ARMED = 2'd1,
    UART_RXF_FIRED = 2'd2
  } rxf_state_e;

  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port memory: one write port, one registered read port.
module fifo_mem_sdp #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Reading a location written on the same edge returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT FIFO with error tags,
// overrun tracking and an inter-character idle timeout.
//
// state          | meaning
// UART_RXF_EMPTY | FIFO empty, timeout counter idle
// UART_RXF_ARMED | data buffered, counting ce ticks since last write
// UART_RXF_FIRED | timeout already pulsed, waiting for next write
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_error,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_error,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic [DROP_CNT_W-1:0]    drop_count,
  input  logic                     overrun_clear,
  output logic                     idle_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = TIMEOUT_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full, pop, wr_en, drop, bypass;
  logic          m_valid_q, byp_sel_q;
  logic [DATA_WIDTH:0] byp_word_q, mem_rd_word;

  logic                  overrun_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  rxf_state_e               state_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_sat;
  logic [CW-1:0]            cnt_next;
  logic                     hit, idle_q;

  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop    = m_valid_q && m_ready;
  assign wr_en  = rx_ready && (!full || pop);
  assign drop   = rx_ready && full && !pop;

  assign wr_ptr_d = wr_ptr_q + PW'(wr_en);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  // The written slot becomes the head: memory still returns stale data this edge.
  assign bypass = wr_en && (wr_ptr_q == rd_ptr_d);

  fifo_mem_sdp #(
    .DATA_W (DATA_WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({rx_error, rx_data}),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (mem_rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      m_valid_q  <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_word_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= (wr_ptr_d != rd_ptr_d);
      byp_sel_q <= bypass;
      if (bypass) byp_word_q <= {rx_error, rx_data};
    end
  end

  assign {m_error, m_data} = byp_sel_q ? byp_word_q : mem_rd_word;
  assign m_valid = m_valid_q;
  assign level   = wr_ptr_q - rd_ptr_q;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overrun_q  <= 1'b1;
      drop_cnt_q <= overrun_clear ? DROP_CNT_W'(1) : sat_inc_drop(drop_cnt_q);
    end else if (overrun_clear) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_cnt_q;

  assign cnt_next = {1'b0, cnt_q} + CW'(1);
  assign cnt_sat  = (cnt_q == '1) ? cnt_q : cnt_next[TIMEOUT_WIDTH-1:0];
  assign hit      = ce && (timeout_cycles != '0) && (cnt_next == {1'b0, timeout_cycles});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_RXF_EMPTY;
      cnt_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      idle_q <= 1'b0;
      if (wr_en) begin
        state_q <= UART_RXF_ARMED;
        cnt_q   <= '0;
      end else if (wr_ptr_d == rd_ptr_d) begin
        state_q <= UART_RXF_EMPTY;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          UART_RXF_ARMED: begin
            if (ce) begin
              cnt_q <= cnt_sat;
              if (hit) begin
                idle_q  <= 1'b1;
                state_q <= UART_RXF_FIRED;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign idle_timeout = idle_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DATA_WIDTH=8).
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready = 1'b0;
  logic        rx_error = 1'b0;
  logic [15:0] timeout_cycles = '0;
  logic [7:0]  m_data;
  logic        m_error;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [4:0]  level;
  logic        overrun;
  logic [7:0]  drop_count;
  logic        overrun_clear = 1'b0;
  logic        idle_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DATA_WIDTH    (8),
    .DEPTH         (16),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce             (ce),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_error       (rx_error),
    .timeout_cycles (timeout_cycles),
    .m_data         (m_data),
    .m_error        (m_error),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .level          (level),
    .overrun        (overrun),
    .drop_count     (drop_count),
    .overrun_clear  (overrun_clear),
    .idle_timeout   (idle_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    m_ready = 1'b0;
    overrun_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [7:0] d, input logic err);
    rx_data = d;
    rx_error = err;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic pop_word();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  // Write one word, optionally rewrite so it lands on edge rewrite_at, and count pulses.
  task automatic timeout_run(input string tag, input logic [15:0] tc, input int rewrite_at,
                             input int exp_pulses, input int exp_first);
    int pulses;
    int first_at;
    pulses = 0;
    first_at = -1;
    do_reset();
    timeout_cycles = tc;
    ce = 1'b1;
    push_word(8'h11, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      if (idle_timeout) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
      rx_data = 8'h22;
      rx_ready = (i == rewrite_at - 1);
      step();
    end
    rx_ready = 1'b0;
    check_val({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check_val({tag, "_first"}, 32'(first_at), 32'(exp_first));
  endtask

  logic [7:0] exp_q [$];

  initial begin
    // Reset state
    do_reset();
    check_val("rst_m_valid", 32'(m_valid), 32'h0);
    check_val("rst_level", 32'(level), 32'h0);
    check_val("rst_m_data", 32'(m_data), 32'h0);
    check_val("rst_m_error", 32'(m_error), 32'h0);
    check_val("rst_overrun", 32'(overrun), 32'h0);
    check_val("rst_drop", 32'(drop_count), 32'h0);
    check_val("rst_idle", 32'(idle_timeout), 32'h0);

    // Single word
    push_word(8'h5A, 1'b0);
    check_val("single_valid", 32'(m_valid), 32'h1);
    check_val("single_data", 32'(m_data), 32'h5A);
    check_val("single_level", 32'(level), 32'h1);
    pop_word();
    check_val("single_pop_valid", 32'(m_valid), 32'h0);
    check_val("single_pop_level", 32'(level), 32'h0);

    // Fill and overrun
    for (int i = 0; i <= 16; i++) push_word(8'(i), 1'b0);
    check_val("fill_level", 32'(level), 32'd16);
    check_val("fill_overrun", 32'(overrun), 32'h1);
    check_val("fill_drop", 32'(drop_count), 32'h1);
    for (int i = 0; i < 260; i++) push_word(8'hEE, 1'b0);
    check_val("sat_drop", 32'(drop_count), 32'd255);
    check_val("sat_level", 32'(level), 32'd16);
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    check_val("clr_overrun", 32'(overrun), 32'h0);
    check_val("clr_drop", 32'(drop_count), 32'h0);

    // Full with simultaneous write and pop
    check_val("full_head", 32'(m_data), 32'h00);
    rx_data = 8'hAA;
    rx_ready = 1'b1;
    m_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    m_ready = 1'b0;
    check_val("wrpop_level", 32'(level), 32'd16);
    check_val("wrpop_overrun", 32'(overrun), 32'h0);
    exp_q.delete();
    for (int i = 1; i <= 15; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hAA);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("drain_%0d", k), 32'(m_data), 32'(exp_q[k]));
      step();
    end
    m_ready = 1'b0;
    check_val("drain_valid", 32'(m_valid), 32'h0);
    check_val("drain_level", 32'(level), 32'h0);

    // Error tag and clear-vs-drop
    do_reset();
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b0);
    check_val("err_data", 32'(m_data), 32'h33);
    check_val("err_tag", 32'(m_error), 32'h1);
    pop_word();
    check_val("err_next_data", 32'(m_data), 32'h44);
    check_val("err_next_tag", 32'(m_error), 32'h0);
    for (int i = 0; i < 17; i++) push_word(8'h50 + 8'(i), 1'b0);
    check_val("err_full_level", 32'(level), 32'd16);
    check_val("err_drop2", 32'(drop_count), 32'd2);
    rx_ready = 1'b1;
    overrun_clear = 1'b1;
    step();
    rx_ready = 1'b0;
    overrun_clear = 1'b0;
    check_val("clrdrop_overrun", 32'(overrun), 32'h1);
    check_val("clrdrop_count", 32'(drop_count), 32'h1);

    // Idle timeout
    timeout_run("to_basic", 16'd10, 0, 1, 11);
    timeout_run("to_restart", 16'd10, 10, 1, 20);
    timeout_run("to_disabled", 16'd0, 0, 0, -1);
    ce = 1'b0;

    // Asynchronous reset mid-burst
    do_reset();
    for (int i = 1; i <= 5; i++) push_word(8'h80 + 8'(i), 1'b0);
    check_val("ar_pre_level", 32'(level), 32'd5);
    check_val("ar_pre_data", 32'(m_data), 32'h81);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_level", 32'(level), 32'h0);
    check_val("ar_valid", 32'(m_valid), 32'h0);
    check_val("ar_data", 32'(m_data), 32'h0);
    #2;
    rst_n = 1'b1;
    push_word(8'h01, 1'b0);
    check_val("ar_post_level", 32'(level), 32'h1);
    check_val("ar_post_data", 32'(m_data), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
